serial_result_writer: RTL and testbench
=======================================

Name: serial_result_writer

Overview:
- Write-back counterpart of the serial data loader.
- Accepts 16-bit partial sums from the PE/accumulator through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each result into two byte writes (low byte, then high byte) to the shared 64x8 scratch memory, starting at a programmable result base address.
- Raises a done flag once NUM_RESULTS results have been written.

Parameters:
- NUM_RESULTS, 4: results per run. Legal range 1..32.
- FIFO_DEPTH, 2: psum buffer entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable. Level sensitive.
- result_baseaddr  in  8  byte address of result 0 (low byte).
- psum_valid  in  1  psum is valid this cycle.
- psum  in  16  signed partial sum from the PE.
- psum_ready  out  1  writer can accept a psum (equals !fifo_full).
- addr  out  6  memory byte address.
- d  out  8  memory write data.
- we  out  1  memory write enable.
- is_done_o  out  1  all NUM_RESULTS results written.
- overflow_o  out  1  sticky flag: psum_valid was seen while psum_ready was low.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: we=0, addr=0, d=0, is_done_o=0, overflow_o=0, psum_ready=1.
  - Internal: FIFO empty, idx=0, state=IDLE.
- Push rule:
  - A psum is pushed when psum_valid && psum_ready.
  - psum_ready depends only on the registered FIFO count. It does not rise in the same cycle as a pop.
- Overflow: psum_valid && !psum_ready sets overflow_o. The psum is dropped. overflow_o clears only on rst.
- State machine:
  - IDLE -> WR_LO when en && !fifo_empty.
  - WR_LO -> WR_HI unconditionally.
  - WR_HI pops the FIFO and increments idx. Next state:
    - DONE if idx == NUM_RESULTS-1 (pre-increment value);
    - else WR_LO if en && FIFO still holds an entry after the pop;
    - else IDLE.
  - DONE -> IDLE when en=0. On this transition idx is cleared to 0.
- Outputs are decoded from registered state, idx and FIFO head only. There is no combinational path from psum or psum_valid to addr/d/we.
- WR_LO drives:
  - we=1
  - addr = (result_baseaddr + 2*idx)[5:0]
  - d = head[7:0]
- WR_HI drives:
  - we=1
  - addr = (result_baseaddr + 2*idx + 1)[5:0]
  - d = head[15:8]
- All other states drive we=0. addr and d hold their last value.
- Address arithmetic is 8-bit modulo 256, truncated to 6 bits. A run that crosses 63 wraps to 0; this is not flagged.
- Throughput and latency:
  - 2 cycles per result.
  - Back-to-back results produce continuous we with no idle cycle.
  - First write occurs 1 cycle after the psum lands in the FIFO, i.e. 2 cycles after the accepting edge.
- en behaviour:
  - en falling during WR_LO: WR_HI still completes, so a result is never half-written.
  - The machine then parks in IDLE, with the FIFO retained.
- DONE behaviour:
  - is_done_o=1 throughout DONE.
  - psums are still accepted in DONE and remain queued for the next run.
- Simultaneous push and pop on the same edge: FIFO count is unchanged and the head advances correctly.
- Reset mid-write: we drops immediately. No further write is issued. A partially written result stays in memory.

Decomposition:
- Shared package (serial_pkg):
  - MEM_ADDR_W=6, DATA_W=8, PSUM_W=16.
  - State encoding: IDLE, WR_LO, WR_HI, DONE.
  - Same package the loader uses for its address width.
- One sub-module: serial_result_fifo.
  - Parameterised depth, 16-bit synchronous FIFO with asynchronous active-high reset.
  - Signals: push, pop, head, full, empty, count.
- The FSM and address generation stay in the top module.

Test Plan:
- Basic run:
  - Stimulus: base=0x20; en=1; push psums 0x1234, 0xFFFE, 0x0001, 0x8000 one every 4 cycles.
  - Required writes: mem[0x20..0x27] = 34,12,FE,FF,01,00,00,80.
  - is_done_o rises the cycle after the last WR_HI. overflow_o=0.
- Back-to-back:
  - Stimulus: hold en=0, push 2 psums (FIFO full, psum_ready=0), then set en=1.
  - Required: 4 consecutive we cycles with no gap. psum_ready returns high 1 cycle after the first pop.
- Overflow:
  - Stimulus: FIFO full, en=0, assert psum_valid with 0xAAAA.
  - Required: overflow_o=1 and stays set. 0xAAAA is never written.
- Wrap:
  - Stimulus: base=0x3E, NUM_RESULTS=2, push 0x0102 and 0x0304.
  - Required writes to addr 0x3E, 0x3F, 0x00, 0x01 with data 02, 01, 04, 03.
- en drop mid-result:
  - Stimulus: deassert en during WR_LO.
  - Required: WR_HI still issues. The next result waits until en=1.
  - DONE exits only after en=0; a second run then restarts at idx 0.
- Reset mid-write:
  - Stimulus: assert rst asynchronously during WR_HI.
  - Required: we=0 within the same cycle, FIFO empty, psum_ready=1, is_done_o=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial scratch-memory loader and result writer.
// Holds the memory geometry, the writer state encoding and the byte-address helper.
package serial_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int DATA_W     = 8;
    localparam int PSUM_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    // base + 2*idx + hi, modulo 256; the caller truncates to the memory width.
    function automatic logic [7:0] result_byte_addr(input logic [7:0] base,
                                                    input logic [5:0] idx,
                                                    input logic       hi);
        return base + {1'b0, idx, hi};
    endfunction

endpackage

// File: rtl/serial_result_fifo.sv
// Small synchronous FIFO buffering 16-bit partial sums ahead of the writer.
// Depth is a power of two; pointers wrap naturally and count disambiguates full/empty.
module serial_result_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [PSUM_W-1:0] din,
    output logic [PSUM_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [PSUM_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_result_writer.sv
// Buffers PE partial sums and writes each as two bytes (low, high) into scratch memory.
// Write strobes are decoded from registered state/idx/FIFO head; addr and d hold between writes.
module serial_result_writer
    import serial_pkg::*;
#(
    parameter int NUM_RESULTS = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7:0]            result_baseaddr,
    input  logic                  psum_valid,
    input  logic [PSUM_W-1:0]     psum,
    output logic                  psum_ready,
    output logic [MEM_ADDR_W-1:0] addr,
    output logic [DATA_W-1:0]     d,
    output logic                  we,
    output logic                  is_done_o,
    output logic                  overflow_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [5:0] LAST_IDX = 6'(NUM_RESULTS - 1);

    wr_state_t             state;
    logic [5:0]            idx;
    logic [MEM_ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0]     d_hold;
    logic [PSUM_W-1:0]     head;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    logic                  more_after_pop;
    logic [7:0]            lo_addr;
    logic [7:0]            hi_addr;

    assign psum_ready     = !full;
    assign push           = psum_valid && !full;
    assign pop            = (state == WR_HI);
    assign more_after_pop = (count > CW'(1)) || push;
    assign lo_addr        = result_byte_addr(result_baseaddr, idx, 1'b0);
    assign hi_addr        = result_byte_addr(result_baseaddr, idx, 1'b1);
    assign is_done_o      = (state == DONE);

    serial_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (psum),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        we   = 1'b0;
        addr = addr_hold;
        d    = d_hold;
        case (state)
            WR_LO: begin
                we   = 1'b1;
                addr = lo_addr[MEM_ADDR_W-1:0];
                d    = head[7:0];
            end
            WR_HI: begin
                we   = 1'b1;
                addr = hi_addr[MEM_ADDR_W-1:0];
                d    = head[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (psum_valid && !psum_ready) begin
            overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            addr_hold <= '0;
            d_hold    <= '0;
        end else begin
            addr_hold <= addr;
            d_hold    <= d;
            case (state)
                IDLE: begin
                    if (en && !empty) begin
                        state <= WR_LO;
                    end
                end
                // The high byte always follows, so a result is never left half-written by en.
                WR_LO: state <= WR_HI;
                WR_HI: begin
                    idx <= idx + 6'd1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else if (en && more_after_pop) begin
                        state <= WR_LO;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (!en) begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_result_writer.sv
// Bench for serial_result_writer: directed scenarios plus random traffic against a
// byte-stream reference model, with literal memory-content expectations.
module tb_serial_result_writer;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  base = 8'h00;
    logic        psum_valid = 1'b0;
    logic [15:0] psum = 16'h0000;
    logic        psum_ready;
    logic [5:0]  addr;
    logic [7:0]  d;
    logic        we;
    logic        is_done_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    serial_result_writer #(.NUM_RESULTS(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .result_baseaddr (base),
        .psum_valid      (psum_valid),
        .psum            (psum),
        .psum_ready      (psum_ready),
        .addr            (addr),
        .d               (d),
        .we              (we),
        .is_done_o       (is_done_o),
        .overflow_o      (overflow_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending psums as a queue, progress as results written this run,
    // and the byte currently on the bus (0 none, 1 low byte, 2 high byte).
    logic [15:0] q[$];
    int          m_kind = 0;
    int          m_res = 0;
    bit          m_done = 1'b0;
    bit          m_ovf = 1'b0;
    logic [5:0]  last_addr = 6'h00;
    logic [7:0]  last_d = 8'h00;

    function automatic logic [5:0] exp_addr();
        logic [7:0] a;
        a = base + 8'(2 * m_res + ((m_kind == 2) ? 1 : 0));
        return a[5:0];
    endfunction

    function automatic logic [7:0] exp_d();
        logic [15:0] h;
        h = (q.size() > 0) ? q[0] : 16'h0000;
        return (m_kind == 1) ? h[7:0] : h[15:8];
    endfunction

    always @(posedge clk or posedge rst) begin
        bit pushing;
        int nk;
        if (rst) begin
            q.delete();
            m_kind = 0;
            m_res = 0;
            m_done = 1'b0;
            m_ovf = 1'b0;
            last_addr = 6'h00;
            last_d = 8'h00;
        end else begin
            pushing = psum_valid && (q.size() < DEPTH);
            if (psum_valid && q.size() >= DEPTH) m_ovf = 1'b1;
            if (m_kind != 0) begin
                last_addr = exp_addr();
                last_d = exp_d();
            end
            nk = 0;
            if (m_kind == 1) begin
                nk = 2;
            end else if (m_kind == 2) begin
                void'(q.pop_front());
                m_res++;
                if (m_res == N) m_done = 1'b1;
                else if (en && (q.size() > 0 || pushing)) nk = 1;
            end else if (m_done) begin
                if (!en) begin
                    m_done = 1'b0;
                    m_res = 0;
                end
            end else if (en && q.size() > 0) begin
                nk = 1;
            end
            m_kind = nk;
            if (pushing) q.push_back(psum);
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            check("we", we, m_kind != 0);
            check("addr", addr, (m_kind != 0) ? exp_addr() : last_addr);
            check("d", d, (m_kind != 0) ? exp_d() : last_d);
            check("psum_ready", psum_ready, q.size() < DEPTH);
            check("is_done_o", is_done_o, m_done);
            check("overflow_o", overflow_o, m_ovf);
        end
    end

    // Scratch memory the writer targets.
    logic [7:0] mem [64];
    int         aa_writes = 0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (!rst && we) begin
            mem[addr] = d;
            if (d == 8'hAA) aa_writes++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_one(input logic [15:0] v);
        psum_valid = 1'b1;
        psum = v;
        tick();
        psum_valid = 1'b0;
    endtask

    task automatic wait_we(input int max);
        int k;
        k = 0;
        @(negedge clk);
        while (!we && k < max) begin
            @(negedge clk);
            k++;
        end
        if (!we) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_we: we=%0b after %0d cycles, required 1", we, max);
        end
    endtask

    task automatic check_mem(input string name, input logic [5:0] a, input logic [7:0] exp);
        check(name, mem[a], exp);
    endtask

    initial begin
        logic [7:0] exp_basic [8];
        logic [1:0] exp_ready [4];
        exp_basic = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h80};
        exp_ready = '{2'd0, 2'd0, 2'd1, 2'd1};

        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_we", we, 0);
        check("reset_addr", addr, 0);
        check("reset_d", d, 0);
        check("reset_ready", psum_ready, 1);
        check("reset_done", is_done_o, 0);
        check("reset_ovf", overflow_o, 0);

        // Basic run
        tick();
        base = 8'h20;
        en = 1'b1;
        push_one(16'h1234); tick(3);
        push_one(16'hFFFE); tick(3);
        push_one(16'h0001); tick(3);
        push_one(16'h8000); tick(8);
        for (int i = 0; i < 8; i++) check_mem("basic_mem", 6'(8'h20 + i), exp_basic[i]);
        check("basic_done", is_done_o, 1);
        check("basic_ovf", overflow_o, 0);
        en = 1'b0;
        tick(2);
        check("basic_done_exit", is_done_o, 0);

        // Back-to-back
        push_one(16'hC3C4);
        push_one(16'hD5D6);
        @(negedge clk);
        check("b2b_full_ready", psum_ready, 0);
        tick();
        en = 1'b1;
        wait_we(10);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("b2b_we", we, 1);
            check("b2b_ready", psum_ready, exp_ready[i]);
        end
        tick(2);
        check("b2b_idle_we", we, 0);
        check_mem("b2b_mem0", 6'h20, 8'hC4);
        check_mem("b2b_mem1", 6'h21, 8'hC3);
        check_mem("b2b_mem2", 6'h22, 8'hD6);
        check_mem("b2b_mem3", 6'h23, 8'hD5);

        // Overflow
        en = 1'b0;
        push_one(16'h5152);
        push_one(16'h6364);
        push_one(16'hAAAA);
        @(negedge clk);
        check("ovf_set", overflow_o, 1);
        tick();
        en = 1'b1;
        tick(8);
        check_mem("ovf_mem4", 6'h24, 8'h52);
        check_mem("ovf_mem5", 6'h25, 8'h51);
        check_mem("ovf_mem6", 6'h26, 8'h64);
        check_mem("ovf_mem7", 6'h27, 8'h63);
        check("ovf_done", is_done_o, 1);
        check("ovf_sticky", overflow_o, 1);
        check("ovf_no_aa", aa_writes, 0);
        en = 1'b0;
        tick(2);

        // en drop mid-result
        base = 8'h10;
        push_one(16'h7172);
        push_one(16'h8182);
        en = 1'b1;
        wait_we(10);
        en = 1'b0;
        @(negedge clk);
        check("endrop_hi_we", we, 1);
        check("endrop_hi_addr", addr, 6'h11);
        repeat (3) begin
            @(negedge clk);
            check("endrop_parked", we, 0);
        end
        tick();
        en = 1'b1;
        tick(6);
        push_one(16'h9192); tick(3);
        push_one(16'hA1A2); tick(8);
        check_mem("endrop_m10", 6'h10, 8'h72);
        check_mem("endrop_m11", 6'h11, 8'h71);
        check_mem("endrop_m12", 6'h12, 8'h82);
        check_mem("endrop_m13", 6'h13, 8'h81);
        check_mem("endrop_m14", 6'h14, 8'h92);
        check_mem("endrop_m15", 6'h15, 8'h91);
        check_mem("endrop_m16", 6'h16, 8'hA2);
        check_mem("endrop_m17", 6'h17, 8'hA1);
        check("endrop_done", is_done_o, 1);
        tick(3);
        check("done_holds", is_done_o, 1);
        en = 1'b0;
        tick(2);
        check("done_exit", is_done_o, 0);
        base = 8'h30;
        push_one(16'hB1B2);
        en = 1'b1;
        tick(6);
        check_mem("restart_m30", 6'h30, 8'hB2);
        check_mem("restart_m31", 6'h31, 8'hB1);
        en = 1'b0;

        // Wrap across the top of memory
        tick();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        base = 8'h3E;
        en = 1'b1;
        push_one(16'h0102); tick();
        push_one(16'h0304); tick(5);
        push_one(16'h0506);
        push_one(16'h0708); tick(10);
        check_mem("wrap_m3e", 6'h3E, 8'h02);
        check_mem("wrap_m3f", 6'h3F, 8'h01);
        check_mem("wrap_m00", 6'h00, 8'h04);
        check_mem("wrap_m01", 6'h01, 8'h03);
        check_mem("wrap_m02", 6'h02, 8'h06);
        check_mem("wrap_m03", 6'h03, 8'h05);
        check("wrap_done", is_done_o, 1);
        en = 1'b0;
        tick(2);

        // Reset during the high-byte write
        push_one(16'hE1E2);
        push_one(16'hF1F2);
        en = 1'b1;
        wait_we(10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rstmid_we", we, 0);
        check("rstmid_ready", psum_ready, 1);
        check("rstmid_done", is_done_o, 0);
        check("rstmid_addr", addr, 0);
        check_mem("rstmid_lo_kept", 6'h3E, 8'hE2);
        check_mem("rstmid_hi_unwritten", 6'h3F, 8'h01);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("rstmid_idle_we", we, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            psum_valid = ($urandom_range(0, 2) == 0);
            psum = 16'($urandom);
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 50) == 0) base = 8'($urandom);
            tick();
        end
        psum_valid = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
